// File: rtl/jtgng_ram_bus.sv
// jtgng_ram_bus: 6809 main-CPU address decode, shared work RAM, control registers, input mux, ROM banking and VBLANK IRQ
module jtgng_ram_bus #(
    parameter int coinw = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen6,
    input  logic             soft_rst,
    input  logic [15:0]      A,
    input  logic             RnW,
    input  logic [7:0]       cpu_dout,
    input  logic             BS,
    input  logic             BA,
    input  logic             LVBL,
    input  logic             blcnten,
    input  logic [8:0]       obj_AB,
    input  logic [7:0]       char_dout,
    input  logic [7:0]       scr_dout,
    input  logic [7:0]       rom_dout,
    input  logic [1:0]       start_button,
    input  logic [1:0]       coin_input,
    input  logic [5:0]       joystick1,
    input  logic [5:0]       joystick2,
    input  logic [15:0]      dipsw,
    output logic [7:0]       cpu_din,
    output logic [7:0]       ram_dout,
    output logic [12:0]      cpu_AB,
    output logic             main_cs,
    output logic             char_cs,
    output logic             scr_cs,
    output logic             scrpos_cs,
    output logic             blue_cs,
    output logic             redgreen_cs,
    output logic             OKOUT,
    output logic             flip,
    output logic             sres_b,
    output logic [7:0]       snd_latch,
    output logic [coinw-1:0] coin_cnt1,
    output logic [coinw-1:0] coin_cnt2,
    output logic [16:0]      rom_addr,
    output logic             nRESET,
    output logic             nIRQ,
    output logic             bus_ack
);
    logic        ram_cs, in_cs, sound_cs, flip_cs, bank_cs, last_LVBL, ram_we;
    logic [2:0]  bank;
    logic [3:0]  rom_hi;
    logic [7:0]  cab;
    logic [12:0] ram_addr;
    logic [7:0]  mem [0:8191];

    assign cpu_AB      = A[12:0];
    assign ram_cs      = A[15:13] == 3'b000;
    assign char_cs     = A[15:11] == 5'b00100;
    assign scr_cs      = A[15:11] == 5'b00101;
    assign in_cs       = A[15:11] == 5'b00110;
    assign redgreen_cs = A[15:8] == 8'h38;
    assign blue_cs     = A[15:8] == 8'h39;
    assign sound_cs    = A[15:8] == 8'h3A;
    assign scrpos_cs   = A[15:8] == 8'h3B;
    assign OKOUT       = A[15:8] == 8'h3C;
    assign flip_cs     = A[15:8] == 8'h3D;
    assign bank_cs     = A[15:8] == 8'h3E;
    assign main_cs     = A[15] | A[14];
    assign bus_ack     = BA & BS;

    always_ff @(posedge clk) begin
        if (rst) begin
            bank      <= 3'd0;
            nRESET    <= 1'b0;
            flip      <= 1'b0;
            sres_b    <= 1'b1;
            coin_cnt1 <= '0;
            coin_cnt2 <= '0;
            snd_latch <= 8'd0;
            nIRQ      <= 1'b1;
            last_LVBL <= 1'b1;
        end else if (cen6) begin
            if (bank_cs && !RnW) bank <= cpu_dout[2:0];
            else nRESET <= ~soft_rst;
            if (flip_cs)
                case (A[2:0])
                    3'd0: flip <= cpu_dout[0];
                    3'd1: sres_b <= cpu_dout[0];
                    3'd2: coin_cnt1 <= coin_cnt1 + coinw'(cpu_dout[0]);
                    3'd3: coin_cnt2 <= coin_cnt2 + coinw'(cpu_dout[0]);
                    default: ;
                endcase
            if (sound_cs) snd_latch <= cpu_dout;
            last_LVBL <= LVBL;
            if ({BS, BA} == 2'b10) nIRQ <= 1'b1;
            else if (last_LVBL && !LVBL) nIRQ <= 1'b0;
        end
    end

    // DMA takes the top 512 bytes of work RAM while it owns the bus
    assign ram_addr = blcnten ? {4'hF, obj_AB} : A[12:0];
    assign ram_we   = !blcnten && ram_cs && !RnW;

    always_ff @(posedge clk) begin
        if (cen6) begin
            if (ram_we) mem[ram_addr] <= cpu_dout;
            ram_dout <= mem[ram_addr];
        end
    end

    always_comb begin
        case (cpu_AB[3:0])
            4'd0: cab = {coin_input, 4'hF, start_button};
            4'd1: cab = {2'b11, joystick1};
            4'd2: cab = {2'b11, joystick2};
            4'd3: cab = dipsw[7:0];
            4'd4: cab = dipsw[15:8];
            default: cab = 8'hFF;
        endcase
    end

    assign cpu_din = ram_cs ? ram_dout : char_cs ? char_dout : scr_cs ? scr_dout : in_cs ? cab : rom_dout;

    always_comb
        rom_hi = A[15] ? {2'b00, A[14:13]} :
                 A[15:13] == 3'b011 ? 4'd5 :
                 A[15:13] == 3'b010 ? (bank == 3'd4 ? 4'd4 : {2'b00, bank[1:0]} + 4'd6) : 4'd0;

    assign rom_addr = {rom_hi, A[12:0]};
endmodule

// File: tb/tb_jtgng_ram_bus.sv
// tb_jtgng_ram_bus: randomized self-checking bench against a behavioural model of the main-CPU bus
module tb_jtgng_ram_bus;
    logic clk = 0, rst = 1, cen6 = 0, soft_rst = 0;
    logic [15:0] A = 0;
    logic RnW = 1;
    logic [7:0] cpu_dout = 0;
    logic BS = 0, BA = 0, LVBL = 1, blcnten = 0;
    logic [8:0] obj_AB = 0;
    logic [7:0] char_dout = 0, scr_dout = 0, rom_dout = 0;
    logic [1:0] start_button = 0, coin_input = 0;
    logic [5:0] joystick1 = 0, joystick2 = 0;
    logic [15:0] dipsw = 0;
    logic [7:0] cpu_din, ram_dout, snd_latch;
    logic [12:0] cpu_AB;
    logic main_cs, char_cs, scr_cs, scrpos_cs, blue_cs, redgreen_cs, OKOUT, flip, sres_b, nRESET, nIRQ, bus_ack;
    logic [3:0] coin_cnt1, coin_cnt2;
    logic [16:0] rom_addr;

    int n_checks = 0, n_fail = 0;
    int m_bank = 0;
    logic [7:0] m_ram [int];

    jtgng_ram_bus #(.coinw(4)) dut (
        .clk(clk), .rst(rst), .cen6(cen6), .soft_rst(soft_rst), .A(A), .RnW(RnW), .cpu_dout(cpu_dout),
        .BS(BS), .BA(BA), .LVBL(LVBL), .blcnten(blcnten), .obj_AB(obj_AB),
        .char_dout(char_dout), .scr_dout(scr_dout), .rom_dout(rom_dout),
        .start_button(start_button), .coin_input(coin_input), .joystick1(joystick1), .joystick2(joystick2), .dipsw(dipsw),
        .cpu_din(cpu_din), .ram_dout(ram_dout), .cpu_AB(cpu_AB),
        .main_cs(main_cs), .char_cs(char_cs), .scr_cs(scr_cs), .scrpos_cs(scrpos_cs), .blue_cs(blue_cs),
        .redgreen_cs(redgreen_cs), .OKOUT(OKOUT), .flip(flip), .sres_b(sres_b), .snd_latch(snd_latch),
        .coin_cnt1(coin_cnt1), .coin_cnt2(coin_cnt2), .rom_addr(rom_addr), .nRESET(nRESET), .nIRQ(nIRQ), .bus_ack(bus_ack)
    );

    always #5 clk = ~clk;
    always @(negedge clk) cen6 = ~cen6;

    task automatic cen_step();
        int n = 0;
        do begin @(posedge clk); n++; end while (cen6 !== 1'b1 && n < 4);
        #1;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        A = a; RnW = 0; cpu_dout = d;
        cen_step();
        RnW = 1; A = 16'h0000;
    endtask

    function automatic int model_rom(input int a, input int bank);
        if (a >= 32'h8000) return a - 32'h8000;
        if (a >= 32'h6000) return a - 32'h6000 + 5 * 8192;
        if (a >= 32'h4000) return a - 32'h4000 + (bank == 4 ? 4 : (bank % 4) + 6) * 8192;
        return a % 8192;
    endfunction

    // {main, char, scr, scrpos, blue, redgreen, OKOUT}
    function automatic logic [6:0] model_cs(input int a);
        int p = a / 256;
        if (a >= 32'h4000) return 7'b1000000;
        if (a >= 32'h2000 && a < 32'h2800) return 7'b0100000;
        if (a >= 32'h2800 && a < 32'h3000) return 7'b0010000;
        if (p == 8'h3B) return 7'b0001000;
        if (p == 8'h39) return 7'b0000100;
        if (p == 8'h38) return 7'b0000010;
        if (p == 8'h3C) return 7'b0000001;
        return 7'b0;
    endfunction

    task automatic test_reset();
        rst = 1;
        repeat (4) @(posedge clk);
        #1; A = 16'h4000;
        #1;
        n_checks++; if (nRESET !== 1'b0) begin n_fail++; $display("FAIL reset_nRESET got %b want 0", nRESET); end
        n_checks++; if (rom_addr !== 17'h0C000) begin n_fail++; $display("FAIL reset_bank rom_addr got %h want 0c000", rom_addr); end
        n_checks++; if ({flip, sres_b, nIRQ, coin_cnt1, coin_cnt2, snd_latch} !== {3'b011, 16'h0}) begin
            n_fail++; $display("FAIL reset_regs got %b%b%b %h %h %h", flip, sres_b, nIRQ, coin_cnt1, coin_cnt2, snd_latch); end
        A = 16'h0000; rst = 0;
        cen_step();
        n_checks++; if (nRESET !== 1'b1) begin n_fail++; $display("FAIL release_nRESET got %b want 1", nRESET); end
        soft_rst = 1;
        cen_step();
        n_checks++; if (nRESET !== 1'b0) begin n_fail++; $display("FAIL soft_rst_nRESET got %b want 0", nRESET); end
        soft_rst = 0;
        cen_step();
        n_checks++; if (nRESET !== 1'b1) begin n_fail++; $display("FAIL soft_rst_release got %b want 1", nRESET); end
    endtask

    task automatic test_bank();
        int exp;
        logic [7:0] b;
        cpu_write(16'h3E00, 8'h04); m_bank = 4;
        A = 16'h4123; #1;
        n_checks++; if (rom_addr !== 17'h08123) begin n_fail++; $display("FAIL bank4 rom_addr got %h want 08123", rom_addr); end
        cpu_write(16'h3E00, 8'h07); m_bank = 7;
        A = 16'h4123; #1;
        n_checks++; if (rom_addr !== 17'h12123) begin n_fail++; $display("FAIL bank7 rom_addr got %h want 12123", rom_addr); end
        A = 16'h8000; #1;
        n_checks++; if (rom_addr !== 17'h00000) begin n_fail++; $display("FAIL rom8000 got %h want 00000", rom_addr); end
        A = 16'h6000; #1;
        n_checks++; if (rom_addr !== 17'h0A000) begin n_fail++; $display("FAIL rom6000 got %h want 0a000", rom_addr); end
        for (int i = 0; i < 24; i++) begin
            b = 8'($urandom_range(0, 7)) | 8'($urandom & 8'hF8);
            cpu_write(16'h3E00, b); m_bank = int'(b[2:0]);
            for (int j = 0; j < 4; j++) begin
                A = 16'($urandom); #1;
                exp = model_rom(int'(A), m_bank);
                n_checks++; if (rom_addr !== 17'(exp)) begin n_fail++; $display("FAIL rom_rand A=%h bank=%0d got %h want %h", A, m_bank, rom_addr, exp); end
                n_checks++; if ({main_cs, char_cs, scr_cs, scrpos_cs, blue_cs, redgreen_cs, OKOUT} !== model_cs(int'(A))) begin
                    n_fail++; $display("FAIL cs_rand A=%h got %b want %b", A, {main_cs, char_cs, scr_cs, scrpos_cs, blue_cs, redgreen_cs, OKOUT}, model_cs(int'(A))); end
            end
        end
        A = 16'h0000;
        n_checks++; if (nRESET !== 1'b1) begin n_fail++; $display("FAIL bank_nRESET got %b want 1", nRESET); end
    endtask

    task automatic test_ram();
        logic [12:0] q [$];
        logic [12:0] a;
        logic [7:0] d;
        cpu_write(16'h0123, 8'h55); m_ram[32'h0123] = 8'h55;
        A = 16'h0123; cen_step();
        n_checks++; if (cpu_din !== 8'h55) begin n_fail++; $display("FAIL ram_read got %h want 55", cpu_din); end
        A = 16'h1000; @(posedge clk); #1;
        n_checks++; if (ram_dout !== 8'h55) begin n_fail++; $display("FAIL ram_hold got %h want 55", ram_dout); end
        A = 16'h0123; RnW = 0; cpu_dout = 8'h66; cen_step(); RnW = 1;
        n_checks++; if (ram_dout !== 8'h55) begin n_fail++; $display("FAIL ram_rbw got %h want 55", ram_dout); end
        m_ram[32'h0123] = 8'h66;
        cpu_write(16'h1FFF, 8'h77); m_ram[32'h1FFF] = 8'h77;
        blcnten = 1; obj_AB = 9'h1FF;
        A = 16'h0123; RnW = 0; cpu_dout = 8'hAA; cen_step(); RnW = 1;
        n_checks++; if (cpu_din !== 8'h77) begin n_fail++; $display("FAIL dma_read got %h want 77", cpu_din); end
        blcnten = 0; A = 16'h0123; cen_step();
        n_checks++; if (cpu_din !== 8'h66) begin n_fail++; $display("FAIL dma_blocks_write got %h want 66", cpu_din); end
        for (int i = 0; i < 30; i++) begin
            a = 13'($urandom); d = 8'($urandom);
            cpu_write({3'b000, a}, d); m_ram[int'(a)] = d; q.push_back(a);
        end
        foreach (q[i]) begin
            blcnten = ($urandom_range(0, 1) == 1) && (q[i][12:9] == 4'hF);
            obj_AB = q[i][8:0];
            A = blcnten ? 16'($urandom_range(0, 16'h1FFF)) : {3'b000, q[i]};
            cen_step();
            n_checks++; if (ram_dout !== m_ram[int'(q[i])]) begin n_fail++; $display("FAIL ram_rand addr=%h dma=%b got %h want %h", q[i], blcnten, ram_dout, m_ram[int'(q[i])]); end
        end
        blcnten = 0; A = 16'h0000;
    endtask

    task automatic test_inputs();
        A = 16'h3000; coin_input = 2'b10; start_button = 2'b01; #1;
        n_checks++; if (cpu_din !== 8'hBD) begin n_fail++; $display("FAIL in_coin got %h want bd", cpu_din); end
        A = 16'h3003; dipsw = 16'hABCD; #1;
        n_checks++; if (cpu_din !== 8'hCD) begin n_fail++; $display("FAIL in_dip_lo got %h want cd", cpu_din); end
        A = 16'h3004; #1;
        n_checks++; if (cpu_din !== 8'hAB) begin n_fail++; $display("FAIL in_dip_hi got %h want ab", cpu_din); end
        A = 16'h3007; #1;
        n_checks++; if (cpu_din !== 8'hFF) begin n_fail++; $display("FAIL in_none got %h want ff", cpu_din); end
        for (int i = 0; i < 10; i++) begin
            joystick1 = 6'($urandom); joystick2 = 6'($urandom);
            A = 16'h3001; #1;
            n_checks++; if (cpu_din !== (8'hC0 | 8'(joystick1))) begin n_fail++; $display("FAIL in_joy1 got %h want %h", cpu_din, 8'hC0 | 8'(joystick1)); end
            A = 16'h3002; #1;
            n_checks++; if (cpu_din !== (8'hC0 | 8'(joystick2))) begin n_fail++; $display("FAIL in_joy2 got %h want %h", cpu_din, 8'hC0 | 8'(joystick2)); end
        end
        char_dout = 8'h12; scr_dout = 8'h34; rom_dout = 8'h56;
        A = 16'h2000; #1;
        n_checks++; if (cpu_din !== 8'h12) begin n_fail++; $display("FAIL din_char got %h want 12", cpu_din); end
        A = 16'h2FFF; #1;
        n_checks++; if (cpu_din !== 8'h34) begin n_fail++; $display("FAIL din_scr got %h want 34", cpu_din); end
        A = 16'h8000; #1;
        n_checks++; if (cpu_din !== 8'h56) begin n_fail++; $display("FAIL din_main got %h want 56", cpu_din); end
        A = 16'h3F00; #1;
        n_checks++; if (cpu_din !== 8'h56) begin n_fail++; $display("FAIL din_none got %h want 56", cpu_din); end
        A = 16'h0000;
    endtask

    task automatic test_control();
        int c1 = 0, c2 = 0;
        logic [7:0] d;
        for (int i = 0; i < 16; i++) begin
            cpu_write(16'h3D02, 8'h01); c1 = (c1 + 1) % 16;
            if (i == 4) begin
                n_checks++; if (coin_cnt1 !== 4'(c1)) begin n_fail++; $display("FAIL coin1_mid got %0d want %0d", coin_cnt1, c1); end
            end
        end
        n_checks++; if (coin_cnt1 !== 4'd0) begin n_fail++; $display("FAIL coin1_wrap got %0d want 0", coin_cnt1); end
        for (int i = 0; i < 12; i++) begin
            d = 8'($urandom); cpu_write(16'h3D03, d); c2 = (c2 + int'(d[0])) % 16;
        end
        n_checks++; if (coin_cnt2 !== 4'(c2)) begin n_fail++; $display("FAIL coin2 got %0d want %0d", coin_cnt2, c2); end
        n_checks++; if (coin_cnt1 !== 4'd0) begin n_fail++; $display("FAIL coin1_untouched got %0d want 0", coin_cnt1); end
        cpu_write(16'h3D00, 8'h01);
        n_checks++; if (flip !== 1'b1) begin n_fail++; $display("FAIL flip got %b want 1", flip); end
        cpu_write(16'h3D01, 8'hFE);
        n_checks++; if (sres_b !== 1'b0) begin n_fail++; $display("FAIL sres_b got %b want 0", sres_b); end
        cpu_write(16'h3D05, 8'hFF);
        n_checks++; if ({flip, sres_b, coin_cnt1} !== {2'b10, 4'd0}) begin n_fail++; $display("FAIL flip_idle got %b%b %0d", flip, sres_b, coin_cnt1); end
        cpu_write(16'h3A00, 8'h5A);
        n_checks++; if (snd_latch !== 8'h5A) begin n_fail++; $display("FAIL snd_latch got %h want 5a", snd_latch); end
    endtask

    task automatic test_irq();
        LVBL = 1; cen_step();
        LVBL = 0; cen_step();
        n_checks++; if (nIRQ !== 1'b0) begin n_fail++; $display("FAIL irq_set got %b want 0", nIRQ); end
        cen_step();
        n_checks++; if (nIRQ !== 1'b0) begin n_fail++; $display("FAIL irq_hold got %b want 0", nIRQ); end
        BS = 1; BA = 0; cen_step();
        n_checks++; if (nIRQ !== 1'b1) begin n_fail++; $display("FAIL irq_ack got %b want 1", nIRQ); end
        BS = 0; LVBL = 1; cen_step();
        LVBL = 0; BS = 1; cen_step();
        n_checks++; if (nIRQ !== 1'b1) begin n_fail++; $display("FAIL irq_ack_priority got %b want 1", nIRQ); end
        BS = 1; BA = 1; #1;
        n_checks++; if (bus_ack !== 1'b1) begin n_fail++; $display("FAIL bus_ack got %b want 1", bus_ack); end
        BA = 0; #1;
        n_checks++; if (bus_ack !== 1'b0) begin n_fail++; $display("FAIL bus_ack_low got %b want 0", bus_ack); end
        BS = 0;
    endtask

    initial begin
        test_reset();
        test_bank();
        test_ram();
        test_inputs();
        test_control();
        test_irq();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/jtgng_ram_bus.md
Name: jtgng_ram_bus

Overview:
- Main-CPU memory/IO subsystem for the Ghosts'n Goblins 6809 board; excludes the CPU core.
- Decodes the 16-bit CPU address into chip selects and holds the 8 KB work RAM, which is shared with the object DMA.
- Also provides the bank, flip, sound-reset, coin and sound-latch registers, the cabinet input mux, the CPU read-data mux, ROM address banking and VBLANK IRQ generation.

Parameters:
- coinw, 4, coin counter width

Ports:
- clk in 1: system clock
- rst in 1: synchronous, active-high reset
- cen6 in 1: 6 MHz clock enable; all state updates require it
- soft_rst in 1: soft reset request
- A in 16: CPU address
- RnW in 1: CPU read(1)/write(0)
- cpu_dout in 8: CPU write data
- BS, BA in 1 each: CPU bus status
- LVBL in 1: vertical blank, active low
- blcnten in 1: object DMA owns the RAM
- obj_AB in 9: DMA address
- char_dout, scr_dout, rom_dout in 8 each: read data from other blocks
- start_button in 2, coin_input in 2, joystick1 in 6, joystick2 in 6, dipsw in 16: cabinet inputs
- cpu_din out 8: CPU read data
- ram_dout out 8: RAM registered output
- cpu_AB out 13: A[12:0]
- main_cs, char_cs, scr_cs, scrpos_cs, blue_cs, redgreen_cs, OKOUT out 1 each: chip selects
- flip out 1, sres_b out 1, snd_latch out 8: control registers
- coin_cnt1, coin_cnt2 out coinw each: coin counters
- rom_addr out 17: banked ROM address
- nRESET out 1: CPU reset
- nIRQ out 1: CPU IRQ
- bus_ack out 1: bus acknowledge

Behaviour:
- Decode on A[15:8], combinational, exactly one select or none:
  - 3A: sound
  - 3C: OKOUT
  - 3B: scrpos
  - 28-2F: scr
  - 30-37: in
  - 39: blue
  - 38: redgreen
  - 3D: flip
  - 00-1F: ram
  - 20-27: char
  - 3E: bank
  - 40-FF: main
  - 3F: none
- Reset values:
  - bank=0, nRESET=0, flip=0, sres_b=1, coin counters=0, snd_latch=0, nIRQ=1, last_LVBL=1.
  - RAM contents are not reset.
- Bank/nRESET, on cen6:
  - bank_cs && !RnW: bank<=cpu_dout[2:0]; nRESET holds its value.
  - Otherwise nRESET<=~(rst|soft_rst).
- Flip-area registers, on cen6 && flip_cs (any RnW), selected by A[2:0]:
  - 0: flip<=cpu_dout[0]
  - 1: sres_b<=cpu_dout[0]
  - 2: coin_cnt1 += cpu_dout[0], wraps modulo 2^coinw
  - 3: coin_cnt2 += cpu_dout[0], wraps modulo 2^coinw
  - 4-7: no effect
- snd_latch: on cen6 && sound_cs, snd_latch<=cpu_dout.
- Cabinet mux by cpu_AB[3:0]:
  - 0: {coin_input, 4'hF, start_button}
  - 1: {2'b11, joystick1}
  - 2: {2'b11, joystick2}
  - 3: dipsw[7:0]
  - 4: dipsw[15:8]
  - else: FF
- RAM (8K x 8):
  - Address: blcnten ? {4'hF, obj_AB} : A[12:0].
  - Write enable: !blcnten && ram_cs && !RnW.
  - On posedge clk with cen6: write mem if enabled; ram_dout<=old mem[addr] (read-before-write).
  - ram_dout holds when cen6=0.
- cpu_din select, one-hot on {ram, char, scr, main, in}:
  - ram: ram_dout
  - char: char_dout
  - scr: scr_dout
  - main: rom_dout
  - in: cabinet mux
  - otherwise: rom_dout
- rom_addr (combinational):
  - rom_addr[12:0]=A[12:0].
  - A[15]=1: [16:13]={2'b00, A[14:13]}.
  - A[15:13]=011: [16:13]=5.
  - A[15:13]=010: [16:13] = 4 if bank==4, else {2'b00, bank[1:0]}+6 (4-bit; bank 0..3, 5..7 map to 6..9).
  - Otherwise: [16:13]=0.
- IRQ, on cen6:
  - last_LVBL<=LVBL.
  - {BS,BA}==2'b10 sets nIRQ=1; this acknowledge has priority.
  - Else a falling edge of LVBL (last_LVBL=1, LVBL=0) sets nIRQ=0.
  - Otherwise nIRQ holds.
- bus_ack = BA & BS, combinational.
- cpu_AB = A[12:0].

Test Plan:
- Reset check: after rst, nRESET=0 and bank=0. Release with soft_rst=0 -> nRESET=1 at the next cen6. Assert soft_rst=1 -> nRESET=0 at the next cen6.
- Bank write: write 3E00<=04, read A=4123 -> rom_addr=0x08123. Write 07 -> rom_addr=0x12123. A=8000 -> rom_addr 0x00000; A=6000 -> 0x0A000.
- RAM: write 55 to 0123, read 0123 -> cpu_din=55 one cen6 later. With blcnten=1 and obj_AB=0x1FF, reading reads 1FFF, and a CPU write is blocked.
- Inputs: A=3000, coin_input=2'b10, start_button=2'b01 -> cpu_din=BD. A=3003, dipsw=0xABCD -> cpu_din=CD. A=3007 -> FF.
- Control: write 3D02 with bit0=1 sixteen times -> coin_cnt1 wraps to 0. Write 3D00<=01 -> flip=1. Write 3A00<=5A -> snd_latch=5A.
- IRQ: LVBL 1->0 -> nIRQ=0 at that cen6. BS=1, BA=0 -> nIRQ=1 next cen6. BS=BA=1 -> bus_ack=1.
